// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling on i_half, ready/valid output.
// Optional parity bit between data and stop is compiled in with `define UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DataBits  = 8,
  parameter bit ParityOdd = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx,
  input  logic                i_half,
  output logic                o_prescaler_en,
  output logic [DataBits-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_frame_err,
  output logic                o_parity_err,
  output logic                o_overrun,
  output logic                o_busy
);

  localparam int CntW = (DataBits > 1) ? $clog2(DataBits) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BRK_WAIT
  } state_t;

  state_t              state, next_state;
  logic                rx_meta, rxs;
  logic [DataBits-1:0] shift;
  logic [CntW-1:0]     bit_cnt;
  logic                last_bit;
  logic                shift_en;
  logic                cnt_clr;
  logic                commit;
  logic                frame_err_set;
  logic                prescaler_en_d;
  logic                handshake;

  assign last_bit  = (bit_cnt == CntW'(DataBits - 1));
  assign handshake = o_valid & i_ready;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_err_set;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (!rxs) next_state = S_START;
      S_START:    if (i_half) next_state = rxs ? S_IDLE : S_DATA;
      S_DATA:
        if (i_half && last_bit) begin
`ifdef UART_RX_PARITY_EN
          next_state = S_PARITY;
`else
          next_state = S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      S_PARITY:   if (i_half) next_state = S_STOP;
`endif
      S_STOP:     if (i_half) next_state = rxs ? S_IDLE : S_BRK_WAIT;
      S_BRK_WAIT: if (rxs) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Strobes for the datapath; a word with a bad parity bit still waits for its stop bit.
  always_comb begin
    shift_en       = (state == S_DATA) && i_half;
    cnt_clr        = (state == S_START);
    frame_err_set  = (state == S_STOP) && i_half && !rxs;
`ifdef UART_RX_PARITY_EN
    par_err_set    = (state == S_PARITY) && i_half && (rxs != ((^shift) ^ ParityOdd));
    commit         = (state == S_STOP) && i_half && rxs && !par_bad;
`else
    commit         = (state == S_STOP) && i_half && rxs;
`endif
    prescaler_en_d = (next_state != S_IDLE) && (next_state != S_BRK_WAIT);
    o_busy         = (state != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta        <= 1'b1;
      rxs            <= 1'b1;
      shift          <= '0;
      bit_cnt        <= '0;
      o_data         <= '0;
      o_valid        <= 1'b0;
      o_overrun      <= 1'b0;
      o_frame_err    <= 1'b0;
      o_prescaler_en <= 1'b0;
    end else begin
      rx_meta        <= i_rx;
      rxs            <= rx_meta;
      o_prescaler_en <= prescaler_en_d;
      o_frame_err    <= frame_err_set;
      o_overrun      <= commit && o_valid && !i_ready;
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shift   <= {rxs, shift[DataBits-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (commit) begin
        o_data  <= shift;
        o_valid <= 1'b1;
      end else if (handshake) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      par_bad      <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      o_parity_err <= par_err_set;
      if (cnt_clr)          par_bad <= 1'b0;
      else if (par_err_set) par_bad <= 1'b1;
    end
  end
`else
  assign o_parity_err = 1'b0 & ParityOdd;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with a divide-by-16 prescaler model and a word scoreboard.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BitCycles = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       half;
  logic       prescaler_en;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.DataBits(8), .ParityOdd(1'b0)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rx           (rx),
    .i_half         (half),
    .o_prescaler_en (prescaler_en),
    .o_data         (data),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_frame_err    (frame_err),
    .o_parity_err   (parity_err),
    .o_overrun      (overrun),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Prescaler model: restarts while disabled, mid-bit pulse every BitCycles cycles.
  logic [3:0] pre_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      half    <= 1'b0;
    end else if (!prescaler_en) begin
      pre_cnt <= '0;
      half    <= 1'b0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      half    <= (pre_cnt == 4'd7);
    end
  end

  typedef struct {
    logic [7:0] word;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_q[$];
  int         tests;
  int         errors;
  int         valid_cycles;
  int         ferr_cnt;
  int         perr_cnt;
  int         ovr_cnt;
  int         b_valid, b_ferr, b_perr, b_ovr;

  task automatic checkOutput(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge; pops the scoreboard on each handshake.
  task automatic sampleOutputs();
    if (valid) valid_cycles++;
    if (frame_err) ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (overrun) ovr_cnt++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_word", int'(data), -1);
      end else begin
        checkOutput("rx_word", int'(data), int'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sampleOutputs();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    ticks(BitCycles);
  endtask

  task automatic applyStimulus(input logic [7:0] word, input logic stop, input logic par_flip);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(word[i]);
`ifdef UART_RX_PARITY_EN
    driveBit((^word) ^ par_flip);
`else
    if (par_flip) $display("[TB] parity flip ignored without parity bit");
`endif
    driveBit(stop);
  endtask

  task automatic snapshot();
    b_valid = valid_cycles;
    b_ferr  = ferr_cnt;
    b_perr  = perr_cnt;
    b_ovr   = ovr_cnt;
  endtask

  initial begin
    tests = 0; errors = 0;
    valid_cycles = 0; ferr_cnt = 0; perr_cnt = 0; ovr_cnt = 0;
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 1, 0};

    rst_n = 1'b0; rx = 1'b1; ready = 1'b1;
    ticks(3);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_prescaler_en", int'(prescaler_en), 0);
    checkOutput("reset_data", int'(data), 0);
    rst_n = 1'b1;
    ticks(4);

    // Table-driven frames with the consumer always ready.
    for (int v = 0; v < 5; v++) begin
      snapshot();
      if (vecs[v].exp_valid != 0) exp_q.push_back(vecs[v].word);
      applyStimulus(vecs[v].word, vecs[v].stop, 1'b0);
      rx = 1'b1;
      ticks(6);
      checkOutput("vec_valid_cycles", valid_cycles - b_valid, vecs[v].exp_valid);
      checkOutput("vec_frame_err", ferr_cnt - b_ferr, vecs[v].exp_ferr);
      checkOutput("vec_parity_err", perr_cnt - b_perr, 0);
      checkOutput("vec_overrun", ovr_cnt - b_ovr, 0);
      checkOutput("vec_busy_idle", int'(busy), 0);
      checkOutput("vec_queue_empty", exp_q.size(), 0);
    end

    // Glitch shorter than a half bit: start aborted without any output.
    snapshot();
    rx = 1'b0;
    ticks(4);
    rx = 1'b1;
    ticks(4);
    checkOutput("false_start_busy", int'(busy), 1);
    checkOutput("false_start_en", int'(prescaler_en), 1);
    ticks(16);
    checkOutput("false_start_idle", int'(busy), 0);
    checkOutput("false_start_en_drop", int'(prescaler_en), 0);
    checkOutput("false_start_valid", valid_cycles - b_valid, 0);

    // Break: stop bit low and line held low for 20 bit times.
    snapshot();
    applyStimulus(8'h3C, 1'b0, 1'b0);
    ticks(20 * BitCycles);
    checkOutput("break_frame_err", ferr_cnt - b_ferr, 1);
    checkOutput("break_valid", valid_cycles - b_valid, 0);
    checkOutput("break_busy", int'(busy), 1);
    checkOutput("break_en", int'(prescaler_en), 0);
    rx = 1'b1;
    ticks(5);
    checkOutput("break_release_busy", int'(busy), 0);
    snapshot();
    exp_q.push_back(8'h01);
    applyStimulus(8'h01, 1'b1, 1'b0);
    ticks(6);
    checkOutput("after_break_valid", valid_cycles - b_valid, 1);
    checkOutput("after_break_queue", exp_q.size(), 0);

    // Overrun: two back-to-back frames with the consumer stalled.
    ready = 1'b0;
    snapshot();
    exp_q.push_back(8'h22);
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    ticks(4);
    checkOutput("overrun_pulses", ovr_cnt - b_ovr, 1);
    checkOutput("overrun_data", int'(data), 8'h22);
    checkOutput("overrun_valid", int'(valid), 1);
    ready = 1'b1;
    tick();
    checkOutput("overrun_drain_valid", int'(valid), 0);
    checkOutput("overrun_queue", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    snapshot();
    exp_q.push_back(8'h07);
    applyStimulus(8'h07, 1'b1, 1'b0);
    ticks(6);
    checkOutput("parity_good_valid", valid_cycles - b_valid, 1);
    checkOutput("parity_good_err", perr_cnt - b_perr, 0);
    snapshot();
    applyStimulus(8'h07, 1'b1, 1'b1);
    ticks(6);
    checkOutput("parity_bad_err", perr_cnt - b_perr, 1);
    checkOutput("parity_bad_valid", valid_cycles - b_valid, 0);
    checkOutput("parity_bad_ferr", ferr_cnt - b_ferr, 0);
`endif

    // Reset in the middle of the data bits of 0x5A.
    snapshot();
    driveBit(1'b0);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    driveBit(1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_valid", int'(valid), 0);
    checkOutput("midreset_en", int'(prescaler_en), 0);
    checkOutput("midreset_data", int'(data), 0);
    checkOutput("midreset_errs", int'({frame_err, parity_err, overrun}), 0);
    rx = 1'b1;
    ticks(5);
    rst_n = 1'b1;
    ticks(4);
    exp_q.push_back(8'hC3);
    applyStimulus(8'hC3, 1'b1, 1'b0);
    ticks(6);
    checkOutput("post_reset_valid", valid_cycles - b_valid, 1);
    checkOutput("post_reset_queue", exp_q.size(), 0);
    checkOutput("total_parity_err_default", perr_cnt - b_perr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
